noc_wr_buffer: RTL and testbench
================================

NOC_WR_BUFFER -- requirements
Module: noc_wr_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_MSB, default 15, giving the MSB index of the data bus.
REQ-002 The block SHALL have parameter ADDR_WIDTH_MSB, default 10, giving the MSB index of the address bus.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 3, giving the buffer depth DEPTH = 2^DEPTH_LOG2 entries.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the producer offers a write.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a write this cycle.
REQ-008 The block SHALL have port in_addr, input, ADDR_WIDTH_MSB+1 bits: write address.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH_MSB+1 bits: write data.
REQ-010 The block SHALL have port noc_valid, output, 1 bit: a write request to the NoC write port.
REQ-011 The block SHALL have port noc_ready, input, 1 bit: the NoC grants the write.
REQ-012 The block SHALL have port noc_addr, output, ADDR_WIDTH_MSB+1 bits: head-entry address.
REQ-013 The block SHALL have port noc_data, output, DATA_WIDTH_MSB+1 bits: head-entry data.
REQ-014 The block SHALL have port fence_req, input, 1 bit: single-cycle pulse requesting a drain.
REQ-015 The block SHALL have port fence_done, output, 1 bit: single-cycle pulse signalling the drain is complete.
REQ-016 The block SHALL have port level, output, DEPTH_LOG2+1 bits: current entry count.
REQ-017 The block SHALL have port wr_count, output, 16 bits: number of NoC transfers completed, wrapping modulo 2^16.

Function
REQ-018 Writes SHALL be stored in a circular buffer of DEPTH entries, with write and read pointers that wrap modulo DEPTH.
REQ-019 A push SHALL occur at a rising edge where in_valid && in_ready; a pop SHALL occur at a rising edge where noc_valid && noc_ready.
REQ-020 in_ready SHALL be combinational: !rst && level != DEPTH && !fence_pending.
REQ-021 noc_valid SHALL be combinational: !rst && level != 0; noc_addr and noc_data SHALL show the head entry.
REQ-022 While noc_valid=1 and noc_ready=0, noc_addr and noc_data SHALL remain stable.
REQ-023 The buffer SHALL NOT pass data through combinationally. A word pushed at edge N SHALL first appear on noc_valid in the cycle after edge N.
REQ-024 A simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-025 When level == DEPTH, in_ready SHALL be 0 even if a pop occurs in the same cycle. Space freed by the pop SHALL be usable from the next cycle.
REQ-026 When level == 0, no pop SHALL occur, and noc_ready SHALL be ignored.
REQ-027 wr_count SHALL increment by 1 on every pop and wrap from 16'hFFFF to 0.
REQ-028 fence_req=1 SHALL set fence_pending at the next edge. A fence_req arriving while fence_pending=1 SHALL be merged, giving a single fence_done.
REQ-029 State machine: IDLE (fence_pending=0) -> FENCE on fence_req; FENCE -> IDLE at the first edge where level==0, with fence_done=1 for exactly the following cycle.
REQ-030 A fence_req issued while level==0 SHALL produce fence_done exactly two cycles after the fence_req cycle.
REQ-031 A push accepted in the same cycle as fence_req SHALL be stored, and the fence SHALL wait for it to drain.
REQ-032 in_valid held while in_ready=0 SHALL be legal; the producer holds in_addr and in_data until accepted.
REQ-033 Write ordering SHALL be preserved: NoC writes leave in exactly push order.

Reset
REQ-034 At a rising edge with rst=1, the block SHALL clear the pointers, level, wr_count, fence_pending and fence_done to 0, and SHALL discard any stored contents.
REQ-035 While rst=1, in_ready and noc_valid SHALL be 0. Reset asserted mid-transfer SHALL drop noc_valid within the same cycle, with no further NoC write.
REQ-036 In the first cycle after rst deasserts, in_ready SHALL be 1, noc_valid 0, and level 0.

Verification
REQ-037 Single write: push (addr 0x010, data 0xBEEF) with noc_ready=1 -> noc_valid high the next cycle with 0x010/0xBEEF, popped, level returns to 0, wr_count=1.
REQ-038 Full/backpressure: noc_ready=0, push 8 words 0..7 -> level=8, in_ready=0; then noc_ready=1 -> data 0..7 emitted in order on 8 consecutive cycles.
REQ-039 Simultaneous push/pop: level=3, in_valid=1 and noc_ready=1 for 10 cycles -> level stays 3 and the data sequence is preserved across pointer wrap.
REQ-040 Fence: 4 entries buffered, noc_ready=0, fence_req pulse -> in_ready=0; noc_ready=1 -> fence_done pulses once, one cycle after level reaches 0, then in_ready=1.
REQ-041 Empty fence: level=0, fence_req at cycle T -> fence_done=1 at T+2 only.
REQ-042 Reset mid-stream: 5 entries stored, noc_valid=1, rst pulsed 1 cycle -> noc_valid=0 during reset; after reset level=0, wr_count=0, and no stale data appears.

Source files
------------

// File: rtl/noc_wr_buffer.sv
// Write buffer between a producer and a NoC write port: a circular FIFO of address/data
// pairs with a fence that blocks new writes until every buffered write has drained.
module noc_wr_buffer #(
  parameter int DATA_WIDTH_MSB = 15,
  parameter int ADDR_WIDTH_MSB = 10,
  parameter int DEPTH_LOG2     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH_MSB:0] in_addr,
  input  logic [DATA_WIDTH_MSB:0] in_data,
  output logic                    noc_valid,
  input  logic                    noc_ready,
  output logic [ADDR_WIDTH_MSB:0] noc_addr,
  output logic [DATA_WIDTH_MSB:0] noc_data,
  input  logic                    fence_req,
  output logic                    fence_done,
  output logic [DEPTH_LOG2:0]     level,
  output logic [15:0]             wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LEVEL_EMPTY = {(DEPTH_LOG2+1){1'b0}};

  typedef enum logic {
    IDLE  = 1'b0,
    FENCE = 1'b1
  } fence_state_t;

  logic [ADDR_WIDTH_MSB:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH_MSB:0] data_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [DEPTH_LOG2:0]     level_r;
  logic [15:0]             wr_count_r;
  fence_state_t            state_r;
  logic                    fence_done_r;
  logic                    fence_pending_s;
  logic                    push_s;
  logic                    pop_s;

  // Full blocks pushes even when a pop happens in the same cycle; the freed slot opens next cycle.
  assign fence_pending_s = (state_r == FENCE);
  assign in_ready        = !rst && (level_r != LEVEL_FULL) && !fence_pending_s;
  assign noc_valid       = !rst && (level_r != LEVEL_EMPTY);
  assign push_s          = in_valid && in_ready;
  assign pop_s           = noc_valid && noc_ready;
  assign noc_addr        = addr_mem_r[rd_ptr_r];
  assign noc_data        = data_mem_r[rd_ptr_r];
  assign fence_done      = fence_done_r;
  assign level           = level_r;
  assign wr_count        = wr_count_r;

  // Entry storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= in_addr;
      data_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, occupancy and completed-transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
      level_r    <= LEVEL_EMPTY;
      wr_count_r <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (DEPTH_LOG2)'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + (DEPTH_LOG2)'(1);
        wr_count_r <= wr_count_r + 16'd1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (DEPTH_LOG2+1)'(1);
        2'b01:   level_r <= level_r - (DEPTH_LOG2+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Fence FSM: a request while already fencing is absorbed into the pending drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      fence_done_r <= 1'b0;
    end else begin
      fence_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fence_req) begin
            state_r <= FENCE;
          end
        end
        FENCE: begin
          if (level_r == LEVEL_EMPTY) begin
            state_r      <= IDLE;
            fence_done_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_wr_buffer.sv
// Directed bench for noc_wr_buffer; a queue scoreboard checks NoC write order and content.
module tb_noc_wr_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_addr;
  logic [15:0] in_data;
  logic        noc_valid;
  logic        noc_ready;
  logic [10:0] noc_addr;
  logic [15:0] noc_data;
  logic        fence_req;
  logic        fence_done;
  logic [3:0]  level;
  logic [15:0] wr_count;

  int vectors;
  int miscompares;
  logic [26:0] sb [$];

  noc_wr_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .noc_valid  (noc_valid),
    .noc_ready  (noc_ready),
    .noc_addr   (noc_addr),
    .noc_data   (noc_data),
    .fence_req  (fence_req),
    .fence_done (fence_done),
    .level      (level),
    .wr_count   (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted writes, compare each NoC transfer against the oldest one.
  always @(negedge clk) begin
    logic [26:0] exp_e;
    if (noc_valid && noc_ready) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        chk("noc_addr", {21'd0, noc_addr}, {21'd0, exp_e[26:16]});
        chk("noc_data", {16'd0, noc_data}, {16'd0, exp_e[15:0]});
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back({in_addr, in_data});
    end
  end

  initial begin
    int n;
    int zero_c;
    int done_c;
    int done_n;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 11'd0;
    in_data   = 16'd0;
    noc_ready = 1'b0;
    fence_req = 1'b0;

    // Reset behaviour
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_noc_valid", {31'd0, noc_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_noc_valid", {31'd0, noc_valid}, 32'd0);
    chk("post_rst_level", {28'd0, level}, 32'd0);
    chk("post_rst_wr_count", {16'd0, wr_count}, 32'd0);

    // Single write, no combinational pass-through
    noc_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 11'h010;
    in_data   = 16'hBEEF;
    #1;
    chk("single_no_passthru", {31'd0, noc_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("single_valid", {31'd0, noc_valid}, 32'd1);
    chk("single_addr", {21'd0, noc_addr}, 32'h010);
    chk("single_data", {16'd0, noc_data}, 32'hBEEF);
    tick();
    chk("single_level", {28'd0, level}, 32'd0);
    chk("single_wr_count", {16'd0, wr_count}, 32'd1);

    // Fill to full under backpressure, then drain
    noc_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_addr  = 11'(i);
      in_data  = 16'(i);
      tick();
    end
    in_addr = 11'h100;
    in_data = 16'h1234;
    #1;
    chk("full_level", {28'd0, level}, 32'd8);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_hold_level", {28'd0, level}, 32'd8);
    noc_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("freed_in_ready", {31'd0, in_ready}, 32'd1);
    chk("freed_level", {28'd0, level}, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("pushpop_level", {28'd0, level}, 32'd7);
    n = 0;
    while (noc_valid && n < 20) begin
      tick();
      n++;
    end
    chk("drain_consecutive", n, 32'd7);
    chk("drain_wr_count", {16'd0, wr_count}, 32'd10);

    // Simultaneous push/pop across pointer wrap
    noc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_addr  = 11'h200 + 11'(i);
      in_data  = 16'hA000 + 16'(i);
      tick();
    end
    noc_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_addr = 11'h300 + 11'(j);
      in_data = 16'hB000 + 16'(j);
      tick();
      if (j == 4) begin
        chk("steady_level_mid", {28'd0, level}, 32'd3);
      end
    end
    in_valid = 1'b0;
    chk("steady_level_end", {28'd0, level}, 32'd3);
    n = 0;
    while (noc_valid && n < 20) begin
      tick();
      n++;
    end
    chk("steady_drain", n, 32'd3);
    chk("steady_wr_count", {16'd0, wr_count}, 32'd23);

    // Fence with buffered entries; last push shares the fence_req cycle, second request merges
    noc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_addr   = 11'h400 + 11'(i);
      in_data   = 16'hC000 + 16'(i);
      fence_req = (i == 3) ? 1'b1 : 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    fence_req = 1'b0;
    #1;
    chk("fence_level", {28'd0, level}, 32'd4);
    chk("fence_in_ready", {31'd0, in_ready}, 32'd0);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    noc_ready = 1'b1;
    zero_c = -1;
    done_c = -1;
    done_n = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (level == 4'd0 && zero_c < 0) zero_c = c;
      if (fence_done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
    end
    chk("fence_done_count", done_n, 32'd1);
    chk("fence_done_timing", done_c, zero_c + 1);
    chk("fence_release_ready", {31'd0, in_ready}, 32'd1);

    // Empty fence: done exactly two cycles after the request cycle
    fence_req = 1'b1;
    #1;
    chk("efence_t0", {31'd0, fence_done}, 32'd0);
    tick();
    fence_req = 1'b0;
    #1;
    chk("efence_t1", {31'd0, fence_done}, 32'd0);
    tick();
    chk("efence_t2", {31'd0, fence_done}, 32'd1);
    tick();
    chk("efence_t3", {31'd0, fence_done}, 32'd0);

    // Reset mid-stream
    noc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_addr  = 11'h500 + 11'(i);
      in_data  = 16'hD000 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("mid_valid", {31'd0, noc_valid}, 32'd1);
    noc_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, noc_valid}, 32'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_post_level", {28'd0, level}, 32'd0);
    chk("mid_post_wr_count", {16'd0, wr_count}, 32'd0);
    chk("mid_post_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    chk("mid_no_stale", {31'd0, noc_valid}, 32'd0);
    in_valid = 1'b1;
    in_addr  = 11'h7AB;
    in_data  = 16'h5A5A;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_new_wr_count", {16'd0, wr_count}, 32'd1);
    chk("sb_final_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
